// File: rtl/alu_pkg.sv
// Shared decode constants and ALU-operation helper for the ALU issue stage.
package alu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;

    typedef struct packed {
        logic [2:0] alu_ctrl;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_store;
        logic       illegal;
    } issue_ctrl_t;

    // Returns {legal, alu_ctrl} for an arithmetic funct3; alt selects sub for funct3 000.
    function automatic logic [3:0] decode_alu(input logic [2:0] funct3, input logic alt);
        logic [3:0] res;
        res = {1'b0, ALU_ADD};
        case (funct3)
            F3_ADD:  res = {1'b1, (alt ? ALU_SUB : ALU_ADD)};
            F3_SLT:  res = {1'b1, ALU_SLT};
            F3_OR:   res = {1'b1, ALU_OR};
            F3_AND:  res = {1'b1, ALU_AND};
            default: res = {1'b0, ALU_ADD};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Sign-extended I/S immediate builder; S-format for stores, I-format otherwise.
module imm_gen
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [31:0]      instr,
    input  logic [6:0]       opcode,
    output logic [WIDTH-1:0] imm
);

    localparam int unsigned EXT_W = WIDTH - 12;

    logic [11:0] imm12;
    logic        unused_bits;

    assign unused_bits = ^{instr[19:12], instr[6:0]};

    always_comb begin
        imm12 = instr[31:20];
        if (opcode == OP_STORE) begin
            imm12 = {instr[31:25], instr[11:7]};
        end
    end

    assign imm = {{EXT_W{imm12[11]}}, imm12};

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue register ahead of the ALU: one-entry valid/ready stage with flush.
// Optional writeback bypass of rs1/rs2 enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SrcA,
    output logic [WIDTH-1:0] SrcB,
    output logic [2:0]       ALUControl,
    output logic [4:0]       rd,
    output logic             reg_write,
    output logic             is_store,
    output logic [WIDTH-1:0] store_data,
    output logic             illegal,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [WIDTH-1:0] wb_data
);

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] rs1_eff;
    logic [WIDTH-1:0] rs2_eff;

    logic [3:0]       alu_dec;
    issue_ctrl_t      dec_ctrl;
    logic [WIDTH-1:0] dec_src_b;

    logic             valid_q,      valid_d;
    logic [WIDTH-1:0] src_a_q,      src_a_d;
    logic [WIDTH-1:0] src_b_q,      src_b_d;
    logic [WIDTH-1:0] store_data_q, store_data_d;
    issue_ctrl_t      ctrl_q,       ctrl_d;

    logic             load;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
        .instr  (instr),
        .opcode (opcode),
        .imm    (imm)
    );

`ifdef ALU_ISSUE_FWD_EN
    // Writeback bypass: x0 is never forwarded.
    always_comb begin
        rs1_eff = rs1_data;
        rs2_eff = rs2_data;
        if (wb_valid && (wb_rd != 5'd0) && (wb_rd == instr[19:15])) begin
            rs1_eff = wb_data;
        end
        if (wb_valid && (wb_rd != 5'd0) && (wb_rd == instr[24:20])) begin
            rs2_eff = wb_data;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_rd, wb_data};
    assign rs1_eff   = rs1_data;
    assign rs2_eff   = rs2_data;
`endif

    // Instruction decode into control fields and operand-B select.
    always_comb begin
        dec_ctrl          = '0;
        dec_ctrl.alu_ctrl = ALU_ADD;
        dec_ctrl.rd       = instr[11:7];
        dec_src_b         = rs2_eff;
        alu_dec           = {1'b0, ALU_ADD};
        case (opcode)
            OP_R: begin
                alu_dec            = decode_alu(funct3, instr[30]);
                dec_ctrl.alu_ctrl  = alu_dec[2:0];
                dec_ctrl.reg_write = alu_dec[3];
                dec_ctrl.illegal   = !alu_dec[3];
            end
            OP_IMM: begin
                alu_dec            = decode_alu(funct3, 1'b0);
                dec_ctrl.alu_ctrl  = alu_dec[2:0];
                dec_ctrl.reg_write = alu_dec[3];
                dec_ctrl.illegal   = !alu_dec[3];
                dec_src_b          = imm;
            end
            OP_LOAD: begin
                dec_ctrl.reg_write = 1'b1;
                dec_src_b          = imm;
            end
            OP_STORE: begin
                dec_ctrl.is_store = 1'b1;
                dec_src_b         = imm;
            end
            OP_BRANCH: begin
                if (funct3 == F3_BEQ) begin
                    dec_ctrl.alu_ctrl = ALU_SUB;
                end else begin
                    dec_ctrl.illegal = 1'b1;
                end
            end
            default: dec_ctrl.illegal = 1'b1;
        endcase
        if (dec_ctrl.illegal) begin
            dec_ctrl.alu_ctrl = ALU_ADD;
        end
        if (dec_ctrl.rd == 5'd0) begin
            dec_ctrl.reg_write = 1'b0;
        end
    end

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready;

    // Next-state: flush beats load, load beats drain; data holds unless loaded.
    always_comb begin
        valid_d      = valid_q;
        src_a_d      = src_a_q;
        src_b_d      = src_b_q;
        store_data_d = store_data_q;
        ctrl_d       = ctrl_q;
        if (flush) begin
            valid_d          = 1'b0;
            ctrl_d.reg_write = 1'b0;
            ctrl_d.is_store  = 1'b0;
            ctrl_d.illegal   = 1'b0;
        end else if (load) begin
            valid_d      = 1'b1;
            src_a_d      = rs1_eff;
            src_b_d      = dec_src_b;
            store_data_d = rs2_eff;
            ctrl_d       = dec_ctrl;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            src_a_q      <= '0;
            src_b_q      <= '0;
            store_data_q <= '0;
            ctrl_q       <= '0;
        end else begin
            valid_q      <= valid_d;
            src_a_q      <= src_a_d;
            src_b_q      <= src_b_d;
            store_data_q <= store_data_d;
            ctrl_q       <= ctrl_d;
        end
    end

    assign out_valid  = valid_q;
    assign SrcA       = src_a_q;
    assign SrcB       = src_b_q;
    assign store_data = store_data_q;
    assign ALUControl = ctrl_q.alu_ctrl;
    assign rd         = ctrl_q.rd;
    assign reg_write  = ctrl_q.reg_write;
    assign is_store   = ctrl_q.is_store;
    assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [2:0]       ALUControl;
    logic [4:0]       rd;
    logic             reg_write;
    logic             is_store;
    logic [WIDTH-1:0] store_data;
    logic             illegal;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .rd         (rd),
        .reg_write  (reg_write),
        .is_store   (is_store),
        .store_data (store_data),
        .illegal    (illegal),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        instr = 32'hFFC10093; rs1_data = 32'd8; rs2_data = 32'd7;
        tick(); tick();
        checks++;
        if ({out_valid, reg_write, is_store, illegal} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {out_valid, reg_write, is_store, illegal});
        end
        checks++;
        if ({SrcA, SrcB, store_data} !== '0) begin
            errors++; $display("FAIL reset_data SrcA %h SrcB %h store %h want 0", SrcA, SrcB, store_data);
        end
        checks++;
        if ({ALUControl, rd} !== 8'h00) begin
            errors++; $display("FAIL reset_ctrl alu %b rd %0d want 0", ALUControl, rd);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || SrcA !== 32'd8) begin
            errors++; $display("FAIL first_accept valid %b SrcA %h want 1 8", out_valid, SrcA);
        end
    endtask

    task automatic test_r_sub();
        instr = 32'h402082B3; rs1_data = 32'd10; rs2_data = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        checks++;
        if (ALUControl !== 3'b001 || SrcA !== 32'd10 || SrcB !== 32'd3 || rd !== 5'd5 || reg_write !== 1'b1) begin
            errors++; $display("FAIL r_sub alu %b A %0d B %0d rd %0d rw %b want 001 10 3 5 1",
                               ALUControl, SrcA, SrcB, rd, reg_write);
        end
    endtask

    task automatic test_addi_neg();
        instr = 32'hFFC10093; rs1_data = 32'd8; rs2_data = 32'd99;
        tick();
        checks++;
        if (SrcB !== 32'hFFFFFFFC || ALUControl !== 3'b000 || SrcA !== 32'd8 || rd !== 5'd1 || reg_write !== 1'b1) begin
            errors++; $display("FAIL addi_neg B %h alu %b A %h rd %0d rw %b want fffffffc 000 8 1 1",
                               SrcB, ALUControl, SrcA, rd, reg_write);
        end
    endtask

    // Back-to-back stream through every decode path.
    task automatic test_decode_table();
        logic [31:0] t_instr [12];
        logic [2:0]  t_alu   [12];
        logic [31:0] t_srcb  [12];
        logic [2:0]  t_flags [12];
        t_instr = '{32'h0020F1B3, 32'h0020E1B3, 32'h0020A1B3, 32'h0050A193,
                    32'h40008193, 32'hFF80A203, 32'hFE20AA23, 32'h00208063,
                    32'h00209063, 32'h00208033, 32'h0000007F, 32'h002081B3};
        t_alu   = '{3'b010, 3'b011, 3'b101, 3'b101, 3'b000, 3'b000,
                    3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
        t_srcb  = '{32'h3C, 32'h3C, 32'h3C, 32'h5, 32'h400, 32'hFFFFFFF8,
                    32'hFFFFFFF4, 32'h3C, 32'h0, 32'h3C, 32'h0, 32'h3C};
        // flags = {reg_write, is_store, illegal}
        t_flags = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                    3'b010, 3'b000, 3'b001, 3'b000, 3'b001, 3'b100};
        in_valid = 1'b1; out_ready = 1'b1; rs2_data = 32'h3C;
        for (int i = 0; i < 12; i++) begin
            instr = t_instr[i]; rs1_data = 32'h100 + 32'(i);
            tick();
            checks++;
            if (out_valid !== 1'b1 || ALUControl !== t_alu[i] || SrcA !== 32'h100 + 32'(i)) begin
                errors++; $display("FAIL decode_%0d valid %b alu %b A %h want 1 %b %h",
                                   i, out_valid, ALUControl, SrcA, t_alu[i], 32'h100 + 32'(i));
            end
            checks++;
            if ({reg_write, is_store, illegal} !== t_flags[i]) begin
                errors++; $display("FAIL decode_flags_%0d got %b want %b", i, {reg_write, is_store, illegal}, t_flags[i]);
            end
            if (t_flags[i][0] == 1'b0) begin
                checks++;
                if (SrcB !== t_srcb[i]) begin
                    errors++; $display("FAIL decode_srcb_%0d got %h want %h", i, SrcB, t_srcb[i]);
                end
            end
            if (t_flags[i][1] == 1'b1) begin
                checks++;
                if (store_data !== 32'h3C) begin
                    errors++; $display("FAIL store_data got %h want 3c", store_data);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        instr = 32'hFFC10093; rs1_data = 32'd8; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        instr = 32'h402082B3; rs1_data = 32'd10; rs2_data = 32'd3;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || SrcB !== 32'hFFFFFFFC || SrcA !== 32'd8 || ALUControl !== 3'b000) begin
                errors++; $display("FAIL hold_%0d rdy %b valid %b A %h B %h alu %b want 0 1 8 fffffffc 000",
                                   i, in_ready, out_valid, SrcA, SrcB, ALUControl);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL release_ready got %b want 1", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || ALUControl !== 3'b001 || SrcA !== 32'd10) begin
            errors++; $display("FAIL queued_load valid %b alu %b A %0d want 1 001 10", out_valid, ALUControl, SrcA);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || SrcA !== 32'd10 || SrcB !== 32'd3) begin
            errors++; $display("FAIL drain valid %b A %0d B %0d want 0 10 3", out_valid, SrcA, SrcB);
        end
    endtask

    task automatic test_flush();
        instr = 32'hFFC10093; rs1_data = 32'd8; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        instr = 32'h402082B3; rs1_data = 32'd10; flush = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || reg_write !== 1'b0) begin
            errors++; $display("FAIL flush valid %b rw %b want 0 0", out_valid, reg_write);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || SrcA !== 32'd8) begin
            errors++; $display("FAIL flush_discard valid %b A %0d want 0 8", out_valid, SrcA);
        end
        rst_n = 1'b0; flush = 1'b1; in_valid = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || SrcA !== 32'd0) begin
            errors++; $display("FAIL reset_over_flush valid %b A %h want 0 0", out_valid, SrcA);
        end
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_fwd();
        logic [31:0] exp_a;
        logic [31:0] exp_sd;
`ifdef ALU_ISSUE_FWD_EN
        exp_a  = 32'h55;
        exp_sd = 32'h55;
`else
        exp_a  = 32'h0;
        exp_sd = 32'h99;
`endif
        wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h55;
        instr = 32'hFFC10093; rs1_data = 32'h0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        checks++;
        if (SrcA !== exp_a) begin
            errors++; $display("FAIL fwd_rs1 got %h want %h", SrcA, exp_a);
        end
        wb_rd = 5'd0; rs1_data = 32'h11;
        tick();
        checks++;
        if (SrcA !== 32'h11) begin
            errors++; $display("FAIL fwd_x0 got %h want 11", SrcA);
        end
        wb_rd = 5'd2; instr = 32'hFE20AA23; rs1_data = 32'h7; rs2_data = 32'h99;
        tick();
        checks++;
        if (store_data !== exp_sd || is_store !== 1'b1) begin
            errors++; $display("FAIL fwd_rs2 store %h st %b want %h 1", store_data, is_store, exp_sd);
        end
        in_valid = 1'b0; wb_valid = 1'b0;
        tick();
    endtask

    initial begin
        wb_valid = 1'b0; wb_rd = 5'd0; wb_data = '0;
        test_reset();
        test_r_sub();
        test_addi_neg();
        test_decode_table();
        test_backpressure();
        test_flush();
        test_fwd();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Decode/issue pipeline register sitting directly upstream of the ALU. It accepts a fetched RV32I instruction plus register-file read data. It decodes the ALU operation and builds the immediate, then registers SrcA, SrcB and ALUControl for the ALU on the next cycle. Valid/ready handshake both sides; supports stall and flush from hazard logic.

Parameters:
WIDTH, 32, datapath width of SrcA/SrcB and register data; immediates sign-extend to WIDTH.

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  upstream presents instruction
in_ready  output  1  stage can accept this cycle
instr  input  32  RV32I instruction word
rs1_data  input  WIDTH  register-file read port 1
rs2_data  input  WIDTH  register-file read port 2
flush  input  1  kill contents, highest priority after reset
out_valid  output  1  SrcA/SrcB/ALUControl valid for ALU
out_ready  input  1  downstream (ALU/execute) accepts
SrcA  output  WIDTH  ALU operand A
SrcB  output  WIDTH  ALU operand B (register or immediate)
ALUControl  output  3  ALU operation select
rd  output  5  destination register
reg_write  output  1  result is written back
is_store  output  1  S-type; rs2 store data in store_data
store_data  output  WIDTH  rs2 value for stores
illegal  output  1  unsupported opcode/funct combination
wb_valid, wb_rd[4:0], wb_data[WIDTH]  input  -  writeback bypass (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at edge): out_valid=0, SrcA=SrcB=store_data=0, ALUControl=000, rd=0, reg_write=0, is_store=0, illegal=0.
- in_ready = !out_valid | out_ready (combinational; one-entry register, no skid buffer).
- Load when in_valid & in_ready: all outputs update at next edge; out_valid=1. Latency 1 cycle.
- Hold when out_valid & !out_ready: all outputs stable, in_ready=0.
- Drain when out_ready & !in_valid: out_valid->0; data outputs hold last value.
- flush=1 at edge: out_valid->0, reg_write->0, is_store->0, illegal->0 regardless of in_valid/out_ready; incoming instruction discarded. rst_n=0 overrides flush.
- ALUControl encoding: 000 add, 001 sub, 010 and, 011 or, 101 slt; others never produced.
- Decode by opcode:
  0110011 R-type: SrcB=rs2; funct3 000 -> add, or sub if funct7[5]=1; 010 slt; 110 or; 111 and; reg_write=1.
  0010011 I-ALU: SrcB=sign-extended I-imm; funct3 as R-type, funct7 ignored (000 always add); reg_write=1.
  0000011 load: add, SrcB=I-imm, reg_write=1.
  0100011 store: add, SrcB=S-imm, is_store=1, store_data=rs2, reg_write=0.
  1100011 beq (funct3 000): sub, SrcB=rs2, reg_write=0.
- Any other opcode/funct3: illegal=1, reg_write=0, ALUControl=000, out_valid still asserted.
- rd=instr[11:7]; reg_write forced 0 when rd=0.
- SrcA=rs1_data in all cases.

Optional Feature:
ALU_ISSUE_FWD_EN. Defined: at load, if wb_valid & wb_rd!=0 & wb_rd==instr[19:15], wb_data replaces rs1_data; same for instr[24:20] vs rs2_data (affects SrcB register path and store_data). Undefined: wb_* ports present but ignored; register-file data used unmodified.

Decomposition:
Package alu_pkg: opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH), ALUControl encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT), funct3 constants. One sub-module imm_gen (instr, opcode -> WIDTH-bit sign-extended I/S immediate), purely combinational.

Test Plan:
- Reset: rst_n=0 two cycles with in_valid=1 -> out_valid=0, all outputs 0; first accept only after rst_n=1.
- R sub: instr=0x40208033 (sub x0?->use rd=x5: 0x402082B3), rs1=10, rs2=3, out_ready=1 -> next cycle ALUControl=001, SrcA=10, SrcB=3, rd=5, reg_write=1.
- I-imm negative: addi x1,x2,-4 (0xFFC10093), rs1=8 -> SrcB=0xFFFFFFFC, ALUControl=000.
- Backpressure: out_ready=0 for 3 cycles after load -> in_ready=0, outputs stable; out_ready=1 -> next queued instruction loads same edge.
- Flush while full and in_valid=1 -> out_valid=0 next cycle, new instr not captured; illegal opcode 0x0000007F -> illegal=1, reg_write=0.
- FWD_EN: wb_valid=1, wb_rd=2, wb_data=0x55, instr reads x2, rs1_data=0 -> SrcA=0x55; with wb_rd=0 -> SrcA=rs1_data.
